// File: rtl/sme_param.sv
`default_nettype none
// ============================================================================
//  Module   : sme_param
//  Brief    : String-matching engine with wildcard, anchor and single-star
//             pattern support, one character comparison per clock.
//  Revision : 1.0
// ============================================================================
module sme_param #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDX_W   = $clog2(STR_MAX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    input  logic             nocase,
    output logic             busy,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index
);
    localparam int PIW = $clog2(PAT_MAX);
    localparam int CW  = IDX_W + PIW + 2;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] SMAX = CW'(STR_MAX);
    localparam logic [CW-1:0] PMAX = CW'(PAT_MAX);
    localparam logic [7:0] CH_DOT = 8'h2E, CH_CARET = 8'h5E, CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR = 8'h2A, CH_SPACE = 8'h20;

    typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      str_q [STR_MAX];
    logic [7:0]      str_d [STR_MAX];
    logic [7:0]      pat_q [PAT_MAX];
    logic [7:0]      pat_d [PAT_MAX];
    logic [CW-1:0]   slen_q, slen_d, plen_q, plen_d;
    logic [CW-1:0]   st_q, st_d, si_q, si_d, pj_q, pj_d;
    logic            nc_q, nc_d, phase_q, phase_d, res_m_q, res_m_d;
    logic [IDX_W-1:0] midx_q, midx_d, res_i_q, res_i_d;

    logic            star_found;
    logic [CW-1:0]   star_pos, need0, need1, need, seg_lo, seg_hi, si_next, seg_end;
    logic [7:0]      tok, ch, prev;
    logic            in_str, is_caret, is_dollar, consume, tok_ok, seg_done;

    function automatic logic [7:0] fold(input logic [7:0] c, input logic nc);
        fold = (nc && c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    endfunction

    // The first '*' splits the pattern into a prefix and a suffix segment;
    // anchors and the star consume no string characters.
    always_comb begin
        star_found = 1'b0;
        star_pos   = '0;
        need0      = '0;
        need1      = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (CW'(i) < plen_q) begin
                if (pat_q[i] == CH_STAR && !star_found) begin
                    star_found = 1'b1;
                    star_pos   = CW'(i);
                end else if (!(i == 0 && pat_q[i] == CH_CARET) &&
                             !(CW'(i) == plen_q - ONE && pat_q[i] == CH_DOLLAR)) begin
                    if (star_found) need1 = need1 + ONE;
                    else            need0 = need0 + ONE;
                end
            end
        end
    end

    // A leading '^' looks at the character before the attempt start, so the
    // attempt start itself is the reported index.
    always_comb begin
        tok       = pat_q[pj_q[PIW-1:0]];
        ch        = str_q[si_q[IDX_W-1:0]];
        prev      = str_q[IDX_W'(si_q - ONE)];
        in_str    = si_q < slen_q;
        is_caret  = (pj_q == '0) && (tok == CH_CARET);
        is_dollar = (pj_q == plen_q - ONE) && (tok == CH_DOLLAR);
        if (is_caret)       tok_ok = (si_q == '0) || (prev == CH_SPACE);
        else if (is_dollar) tok_ok = !in_str || (ch == CH_SPACE);
        else                tok_ok = in_str && ((tok == CH_DOT) || (fold(ch, nc_q) == fold(tok, nc_q)));
        consume = !(is_caret || is_dollar);
        si_next = consume ? si_q + ONE : si_q;
        seg_lo  = phase_q ? star_pos + ONE : '0;
        seg_hi  = phase_q ? plen_q : (star_found ? star_pos : plen_q);
        need    = phase_q ? need1 : need0;
    end

    always_comb begin
        state_d  = state_q;
        str_d    = str_q;
        pat_d    = pat_q;
        slen_d   = slen_q;
        plen_d   = plen_q;
        nc_d     = nc_q;
        phase_d  = phase_q;
        st_d     = st_q;
        si_d     = si_q;
        pj_d     = pj_q;
        midx_d   = midx_q;
        res_m_d  = res_m_q;
        res_i_d  = res_i_q;
        seg_done = 1'b0;
        seg_end  = si_q;
        case (state_q)
            IDLE, LOAD_STR: begin
                if (isstring) begin
                    if (state_q == IDLE) begin
                        str_d[0] = chardata;
                        slen_d   = ONE;
                        state_d  = LOAD_STR;
                    end else if (slen_q < SMAX) begin
                        str_d[slen_q[IDX_W-1:0]] = chardata;
                        slen_d = slen_q + ONE;
                    end
                end else if (ispattern) begin
                    pat_d[0] = chardata;
                    plen_d   = ONE;
                    nc_d     = nocase;
                    state_d  = LOAD_PAT;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_PAT: begin
                if (ispattern && !isstring) begin
                    if (plen_q < PMAX) begin
                        pat_d[plen_q[PIW-1:0]] = chardata;
                        plen_d = plen_q + ONE;
                    end
                end else begin
                    state_d = SEARCH;
                    phase_d = 1'b0;
                    st_d    = '0;
                    si_d    = '0;
                    pj_d    = '0;
                end
            end
            SEARCH: begin
                if (slen_q == '0) begin
                    res_m_d = (plen_q == CW'(2)) && (pat_q[0] == CH_CARET) && (pat_q[1] == CH_DOLLAR);
                    res_i_d = '0;
                    state_d = DONE;
                end else if (st_q + need > slen_q) begin
                    res_m_d = 1'b0;
                    res_i_d = '0;
                    state_d = DONE;
                end else if (pj_q == seg_hi) begin
                    seg_done = 1'b1;
                end else if (tok_ok) begin
                    if (pj_q + ONE == seg_hi) begin
                        seg_done = 1'b1;
                        seg_end  = si_next;
                    end else begin
                        pj_d = pj_q + ONE;
                        si_d = si_next;
                    end
                end else if (st_q + ONE + need > slen_q) begin
                    res_m_d = 1'b0;
                    res_i_d = '0;
                    state_d = DONE;
                end else begin
                    st_d = st_q + ONE;
                    si_d = st_q + ONE;
                    pj_d = seg_lo;
                end
                // Earliest prefix gives the earliest end, so only that one needs a suffix search.
                if (seg_done) begin
                    if (!phase_q && star_found) begin
                        midx_d  = IDX_W'(st_q);
                        phase_d = 1'b1;
                        st_d    = seg_end;
                        si_d    = seg_end;
                        pj_d    = star_pos + ONE;
                    end else begin
                        res_m_d = 1'b1;
                        res_i_d = phase_q ? midx_q : IDX_W'(st_q);
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            str_q   <= '{default: 8'h20};
            pat_q   <= '{default: 8'h20};
            slen_q  <= '0;
            plen_q  <= '0;
            nc_q    <= 1'b0;
            phase_q <= 1'b0;
            st_q    <= '0;
            si_q    <= '0;
            pj_q    <= '0;
            midx_q  <= '0;
            res_m_q <= 1'b0;
            res_i_q <= '0;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            pat_q   <= pat_d;
            slen_q  <= slen_d;
            plen_q  <= plen_d;
            nc_q    <= nc_d;
            phase_q <= phase_d;
            st_q    <= st_d;
            si_q    <= si_d;
            pj_q    <= pj_d;
            midx_q  <= midx_d;
            res_m_q <= res_m_d;
            res_i_q <= res_i_d;
        end
    end

    assign busy        = (state_q == SEARCH) || (state_q == DONE);
    assign valid       = (state_q == DONE);
    assign match       = valid && res_m_q;
    assign match_index = match ? res_i_q : '0;

endmodule
`default_nettype wire
